poly_mul_schb_64_seq: RTL and testbench
=======================================

POLY_MUL_SCHB_64_SEQ -- requirements
Module: poly_mul_schb_64_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095, max cycles waited for mul_done before error.
REQ-002 SHALL have ports:
  clk  in  1  clock; all logic on rising edge.
  resetn  in  1  reset, synchronous, active-low.
  in_valid  in  1  operand word valid.
  in_ready  out  1  operand word accepted when in_valid&in_ready.
  in_data  in  16  operand coefficient; 64 A words, then 64 B words.
  out_valid  out  1  result word valid.
  out_ready  in  1  result word consumed when out_valid&out_ready.
  out_data  out  16  result coefficient.
  out_last  out  1  high with the 128th result word.
  busy  out  1  high in any state but IDLE.
  err  out  1  sticky timeout flag; cleared on next accepted operand word.
  mul_start  out  1  start pulse to multiplier wrapper.
  mul_address  out  7  wrapper memory address.
  mul_data_in  out  16  wrapper write data.
  mul_write_en  out  1  wrapper operand write enable.
  mul_clres  out  1  wrapper result-clear enable.
  mul_data_out  in  16  wrapper result read data, combinational from mul_address.
  mul_done  in  1  wrapper completion.

Function
REQ-003 SHALL implement states IDLE, LOAD, CLEAR, START, WAIT, DRAIN with a 7-bit index counter idx.
REQ-004 IDLE: in_ready=1; first accepted word writes address 0, sets idx=1, goes to LOAD.
REQ-005 LOAD: in_ready=1; each accepted word drives mul_write_en=1, mul_address=idx, mul_data_in=in_data in that cycle, then idx increments; in_valid low stalls with no write.
REQ-006 Words 0-63 SHALL land at addresses 0-63 (A); words 64-127 at 64-127 (B).
REQ-007 After the word at address 127 is accepted: idx wraps to 0, in_ready drops next cycle, state goes to CLEAR.
REQ-008 CLEAR: mul_clres=1, mul_address=idx, for 128 consecutive cycles (addresses 0-127), then START; no stall.
REQ-009 START: mul_start=1 for exactly one cycle; mul_write_en=mul_clres=0; next state WAIT, timeout counter cleared.
REQ-010 WAIT: outputs idle; first cycle mul_done=1 -> DRAIN with idx=0; mul_done in any other state SHALL be ignored.
REQ-011 WAIT timeout: counter reaching TIMEOUT without mul_done SHALL set err=1 and return to IDLE.
REQ-012 DRAIN: mul_address=idx, out_valid=1, out_data=mul_data_out; idx increments only on out_valid&out_ready; out_data stable while stalled.
REQ-013 out_last=1 iff DRAIN and idx=127; handshake on that word returns to IDLE.
REQ-014 mul_write_en and mul_clres SHALL never be high in the same cycle; mul_write_en only in IDLE/LOAD.
REQ-015 in_ready SHALL be 0 in CLEAR, START, WAIT, DRAIN; out_valid 0 outside DRAIN.
REQ-016 Outside LOAD/CLEAR/DRAIN, mul_address SHALL be 0 and mul_data_in SHALL equal in_data.
REQ-017 Throughput: full-rate source/sink SHALL give 128 load + 128 clear + 1 start + multiplier latency + 1 + 128 drain cycles.

Reset
REQ-018 resetn=0 at a clock edge SHALL force IDLE, idx=0, timeout counter=0, err=0, and mul_start, mul_write_en, mul_clres, out_valid, out_last, busy=0, in_ready=1 after the edge.
REQ-019 Reset mid-operation SHALL abandon the operation with no further memory writes; memory contents are left unchanged and a new load restarts at address 0.

Verification
REQ-020 A=x^0 coefficient 1 (others 0), B=k+1 for k=0..63, full-rate both sides -> 128 writes at addresses 0-127, 128 clres cycles, one mul_start, drained words equal reference product, out_last on word 127.
REQ-021 in_valid toggled 1/0 each cycle during load -> exactly 128 writes, addresses strictly increasing, no write in gap cycles.
REQ-022 out_ready low for 5 cycles at word 10 -> out_data, mul_address=10 held stable, no word skipped or duplicated.
REQ-023 Model never asserts mul_done, TIMEOUT=16 -> err=1 17 cycles after mul_start, state IDLE, in_ready=1; next accepted word clears err.
REQ-024 resetn low for 1 cycle during CLEAR at idx=40 -> mul_clres=0 next cycle, busy=0; subsequent full run produces correct result.
REQ-025 mul_done pulsed during LOAD -> ignored; load completes and sequence proceeds normally.

Source files
------------

// File: rtl/poly_mul_schb_64_seq.sv
// Sequencer that streams two 64-coefficient operands into a schoolbook multiplier wrapper,
// clears its result memory, starts it, waits for completion and streams the 128 result words out.
module poly_mul_schb_64_seq #(
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err,
    output logic        mul_start,
    output logic [6:0]  mul_address,
    output logic [15:0] mul_data_in,
    output logic        mul_write_en,
    output logic        mul_clres,
    input  logic [15:0] mul_data_out,
    input  logic        mul_done
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic clres;
        logic start;
        logic out_valid;
        logic busy;
    } flags_t;

    state_t        state;
    flags_t        flags;
    logic [6:0]    idx;
    logic [TW-1:0] tcnt;
    logic          err_q;
    logic          accept;
    logic          drained;

    // Per-state control outputs; registered together with the state so they never glitch.
    function automatic flags_t decode(input state_t s);
        flags_t f;
        f           = '0;
        f.in_ready  = (s == S_IDLE) || (s == S_LOAD);
        f.clres     = (s == S_CLEAR);
        f.start     = (s == S_START);
        f.out_valid = (s == S_DRAIN);
        f.busy      = (s != S_IDLE);
        return f;
    endfunction

    assign accept  = in_valid & flags.in_ready;
    assign drained = flags.out_valid & out_ready;

    assign in_ready     = flags.in_ready;
    assign mul_clres    = flags.clres;
    assign mul_start    = flags.start;
    assign out_valid    = flags.out_valid;
    assign busy         = flags.busy;
    assign err          = err_q;
    assign out_last     = flags.out_valid && (idx == 7'd127);
    assign out_data     = mul_data_out;
    assign mul_data_in  = in_data;
    // Writes are only possible while in_ready is high, i.e. in IDLE or LOAD.
    assign mul_write_en = accept;

    always_comb begin
        mul_address = 7'd0;
        if (state == S_LOAD || state == S_CLEAR || state == S_DRAIN) begin
            mul_address = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            flags <= decode(S_IDLE);
            idx   <= 7'd0;
            tcnt  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        idx   <= 7'd1;
                        err_q <= 1'b0;
                        state <= S_LOAD;
                        flags <= decode(S_LOAD);
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        idx   <= idx + 7'd1;
                        err_q <= 1'b0;
                        if (idx == 7'd127) begin
                            state <= S_CLEAR;
                            flags <= decode(S_CLEAR);
                        end
                    end
                end
                S_CLEAR: begin
                    // idx wraps back to 0 on the last cleared address.
                    idx <= idx + 7'd1;
                    if (idx == 7'd127) begin
                        state <= S_START;
                        flags <= decode(S_START);
                    end
                end
                S_START: begin
                    tcnt  <= '0;
                    state <= S_WAIT;
                    flags <= decode(S_WAIT);
                end
                S_WAIT: begin
                    if (mul_done) begin
                        idx   <= 7'd0;
                        state <= S_DRAIN;
                        flags <= decode(S_DRAIN);
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        // TIMEOUT full cycles spent waiting without completion.
                        tcnt  <= '0;
                        err_q <= 1'b1;
                        state <= S_IDLE;
                        flags <= decode(S_IDLE);
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        idx <= idx + 7'd1;
                        if (idx == 7'd127) begin
                            state <= S_IDLE;
                            flags <= decode(S_IDLE);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    flags <= decode(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mul_schb_64_seq.sv
// Bench for poly_mul_schb_64_seq: behavioural multiplier wrapper plus table-driven full runs
// and hand-written timeout and mid-operation reset sequences.
module tb_poly_mul_schb_64_seq;

    localparam int LAT = 5;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        err;
    logic        mul_start;
    logic [6:0]  mul_address;
    logic [15:0] mul_data_in;
    logic        mul_write_en;
    logic        mul_clres;
    logic [15:0] mul_data_out;
    logic        mul_done;

    always #5 clk = ~clk;

    poly_mul_schb_64_seq #(.TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .mul_start(mul_start), .mul_address(mul_address), .mul_data_in(mul_data_in),
        .mul_write_en(mul_write_en), .mul_clres(mul_clres),
        .mul_data_out(mul_data_out), .mul_done(mul_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wrapper model: operand memory, accumulating result memory, fixed completion latency.
    logic [15:0] opmem [128];
    logic [15:0] res   [128];
    int          lat_cnt    = 0;
    logic        mdone      = 1'b0;
    logic        force_done = 1'b0;
    logic        done_en    = 1'b1;

    function automatic logic [15:0] conv(input int k);
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i < 64; i++)
            if (k - i >= 0 && k - i < 64) s = s + opmem[i] * opmem[64 + k - i];
        return s;
    endfunction

    always @(posedge clk) begin
        mdone <= 1'b0;
        if (mul_write_en) opmem[mul_address] <= mul_data_in;
        if (mul_clres) res[mul_address] <= 16'h0;
        if (mul_start && done_en) lat_cnt <= LAT;
        else if (lat_cnt == 1) begin
            lat_cnt <= 0;
            mdone   <= 1'b1;
            for (int k = 0; k < 128; k++) res[k] <= res[k] + conv(k);
        end else if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
    end

    assign mul_done     = mdone | force_done;
    assign mul_data_out = res[mul_address];

    // Bus monitor on the falling edge.
    int cyc = 0, wr_cnt = 0, clr_cnt = 0, st_cnt = 0, t_first = 0, t_last = 0;

    always @(negedge clk) begin
        cyc++;
        if (resetn === 1'b1) begin
            if (mul_write_en) begin
                check("wr_addr", mul_address, wr_cnt);
                if (wr_cnt == 0) t_first = cyc;
                wr_cnt++;
            end
            if (mul_clres) begin
                check("clr_addr", mul_address, clr_cnt);
                clr_cnt++;
            end
            if (mul_write_en | mul_clres) check("we_clres_excl", mul_write_en & mul_clres, 0);
            if (mul_start) st_cnt++;
            if (out_valid && out_ready && out_last) t_last = cyc;
            if (busy === 1'b0) begin
                check("idle_addr", mul_address, 0);
                check("idle_din", mul_data_in, in_data);
                check("idle_ovalid", out_valid, 0);
            end
        end
    end

    typedef struct {
        int              a_pos;
        logic [15:0]     a_coef;
        int              gap;
        int              stall_at;
        int              force_at;
        logic [3:0][6:0] probe;
        logic [3:0][15:0] expv;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] a_vec [64];
    logic [15:0] words [128];

    task automatic load_all(input int gap, input int force_at);
        for (int k = 0; k < 128; k++) begin
            int   n;
            logic ok;
            n          = 0;
            ok         = 1'b0;
            in_valid   = 1'b1;
            in_data    = (k < 64) ? a_vec[k] : 16'(k - 63);
            force_done = (k == force_at);
            do begin
                @(negedge clk);
                ok = in_ready;
                n++;
                @(posedge clk); #1;
                force_done = 1'b0;
            end while (!ok && n < 20);
            check($sformatf("load_ready[%0d]", k), ok, 1);
            if (k == 0) check("err_clear", err, 0);
            if (gap != 0) begin
                in_valid = 1'b0;
                in_data  = 16'hDEAD;
                @(negedge clk);
                check("gap_we", mul_write_en, 0);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain_all(input int stall_at);
        int          got, n, hold_left;
        logic [15:0] held;
        got       = 0;
        n         = 0;
        hold_left = 5;
        held      = 16'h0;
        while (got < 128 && n < 3000) begin
            out_ready = (got == stall_at && hold_left > 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                if (!out_ready) begin
                    if (hold_left == 5) held = out_data;
                    else check("stall_data", out_data, held);
                    check("stall_addr", mul_address, stall_at);
                    hold_left--;
                end else begin
                    words[got] = out_data;
                    check($sformatf("drain_addr[%0d]", got), mul_address, got);
                    check($sformatf("out_last[%0d]", got), out_last, (got == 127));
                    got++;
                end
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        check("drain_count", got, 128);
    endtask

    task automatic run_vec(input vec_t v, input int idn, input int check_tp);
        for (int i = 0; i < 64; i++) a_vec[i] = (i == v.a_pos) ? v.a_coef : 16'h0;
        wr_cnt  = 0;
        clr_cnt = 0;
        st_cnt  = 0;
        load_all(v.gap, v.force_at);
        drain_all(v.stall_at);
        check($sformatf("wr_total[%0d]", idn), wr_cnt, 128);
        check($sformatf("clr_total[%0d]", idn), clr_cnt, 128);
        check($sformatf("start_total[%0d]", idn), st_cnt, 1);
        for (int p = 0; p < 4; p++)
            check($sformatf("word[%0d] run %0d", v.probe[p], idn), words[v.probe[p]], v.expv[p]);
        if (check_tp != 0) check("cycle_span", t_last - t_first + 1, 391);
        @(negedge clk);
        check("end_busy", busy, 0);
        check("end_ready", in_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int   n, m;
        logic found;

        vecs[0].a_pos = 0;  vecs[0].a_coef = 16'h0001; vecs[0].gap = 0;
        vecs[0].stall_at = -1; vecs[0].force_at = -1;
        vecs[0].probe = {7'd127, 7'd64, 7'd63, 7'd0};
        vecs[0].expv  = {16'h0000, 16'h0000, 16'd64, 16'd1};

        vecs[1].a_pos = 1;  vecs[1].a_coef = 16'h0001; vecs[1].gap = 1;
        vecs[1].stall_at = -1; vecs[1].force_at = -1;
        vecs[1].probe = {7'd65, 7'd64, 7'd1, 7'd0};
        vecs[1].expv  = {16'h0000, 16'd64, 16'd1, 16'h0000};

        vecs[2].a_pos = 63; vecs[2].a_coef = 16'h0002; vecs[2].gap = 0;
        vecs[2].stall_at = -1; vecs[2].force_at = -1;
        vecs[2].probe = {7'd127, 7'd126, 7'd63, 7'd62};
        vecs[2].expv  = {16'h0000, 16'd128, 16'd2, 16'h0000};

        vecs[3].a_pos = 0;  vecs[3].a_coef = 16'hFFFF; vecs[3].gap = 0;
        vecs[3].stall_at = 10; vecs[3].force_at = 30;
        vecs[3].probe = {7'd64, 7'd63, 7'd10, 7'd0};
        vecs[3].expv  = {16'h0000, 16'hFFC0, 16'hFFF5, 16'hFFFF};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_write_en", mul_write_en, 0);
        check("rst_clres", mul_clres, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i, (i == 0) ? 1 : 0);

        // Multiplier never completes: timeout must fire.
        done_en = 1'b0;
        for (int i = 0; i < 64; i++) a_vec[i] = (i == 0) ? 16'h0001 : 16'h0;
        wr_cnt = 0; clr_cnt = 0; st_cnt = 0;
        load_all(0, -1);
        n = 0; found = 1'b0;
        while (!found && n < 1000) begin
            @(negedge clk);
            if (mul_start) found = 1'b1;
            n++;
        end
        check("tmo_start_seen", found, 1);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (err !== 1'b1 && m < 100);
        check("tmo_cycles", m, 17);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        check("tmo_ready", in_ready, 1);
        @(posedge clk); #1;
        check("tmo_err_sticky", err, 1);
        done_en = 1'b1;
        run_vec(vecs[1], 4, 0);
        check("err_after_run", err, 0);

        // Reset while clearing address 40.
        for (int i = 0; i < 64; i++) a_vec[i] = (i == 0) ? 16'h0001 : 16'h0;
        wr_cnt = 0; clr_cnt = 0; st_cnt = 0;
        load_all(0, -1);
        n = 0; found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk);
            if (mul_clres && mul_address == 7'd40) found = 1'b1;
            n++;
        end
        check("rst40_seen", found, 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("rst40_clres", mul_clres, 0);
        check("rst40_busy", busy, 0);
        check("rst40_ready", in_ready, 1);
        check("rst40_start", mul_start, 0);
        check("rst40_ovalid", out_valid, 0);
        @(posedge clk); #1;
        run_vec(vecs[2], 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
